// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl_if
// Brief    : Instruction handshake, ALU stage, write-back and branch signals
//            shared between the issue controller and its surroundings.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if;
    logic [31:0] Instr;
    logic        Instr_valid;
    logic        Instr_ready;
    logic [4:0]  RF_A_addr;
    logic [4:0]  RF_B_addr;
    logic [3:0]  ALU_func;
    logic        ALU_Bin_sel;
    logic [31:0] Immed;
    logic [31:0] ALU_out;
    logic        zero;
    logic        RF_WrEn;
    logic [4:0]  RF_Wr_addr;
    logic [31:0] RF_WrData;
    logic        Branch_taken;
    logic [31:0] Branch_offset;
    logic        Done;
    logic        Illegal;

    // Controller side: consumes instructions and ALU results
    modport slave (
        input  Instr, Instr_valid, ALU_out, zero,
        output Instr_ready, RF_A_addr, RF_B_addr, ALU_func, ALU_Bin_sel, Immed,
               RF_WrEn, RF_Wr_addr, RF_WrData, Branch_taken, Branch_offset,
               Done, Illegal
    );

    // Environment side: supplies instructions and ALU results
    modport master (
        output Instr, Instr_valid, ALU_out, zero,
        input  Instr_ready, RF_A_addr, RF_B_addr, ALU_func, ALU_Bin_sel, Immed,
               RF_WrEn, RF_Wr_addr, RF_WrData, Branch_taken, Branch_offset,
               Done, Illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Four-state (IDLE/DECODE/EXEC/WB) issue controller for a single
//            ALU stage: decodes one instruction, drives ALU controls, captures
//            the ALU result and performs write-back / branch signalling.
// Config   : define ALU_ISSUE_BRANCH_EN to enable beq / bne / b.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl (
    input wire              Clk,
    input wire              Reset_n,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'b100000;
    localparam logic [5:0] c_op_addi  = 6'b110000;
    localparam logic [5:0] c_op_andi  = 6'b110010;
    localparam logic [5:0] c_op_ori   = 6'b110011;
    localparam logic [5:0] c_op_li    = 6'b111000;
    localparam logic [5:0] c_op_lui   = 6'b111001;
    localparam logic [3:0] c_func_add = 4'b0000;
    localparam logic [3:0] c_func_sub = 4'b0001;
    localparam logic [3:0] c_func_and = 4'b0010;
    localparam logic [3:0] c_func_or  = 4'b0011;

`ifdef ALU_ISSUE_BRANCH_EN
    localparam logic [5:0] c_op_beq   = 6'b000000;
    localparam logic [5:0] c_op_bne   = 6'b000001;
    localparam logic [5:0] c_op_b     = 6'b111111;

    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_EQ     = 2'd1,
        BR_NE     = 2'd2,
        BR_ALWAYS = 2'd3
    } br_kind_t;
`endif

    // Instruction fields
    logic [5:0]  w_opcode;
    logic [4:0]  w_rs, w_rd, w_rt;
    logic [15:0] w_imm;
    assign w_opcode = bus.Instr[31:26];
    assign w_rs     = bus.Instr[25:21];
    assign w_rd     = bus.Instr[20:16];
    assign w_rt     = bus.Instr[15:11];
    assign w_imm    = bus.Instr[15:0];

    // Decoded controls for the offered instruction
    logic [3:0]  w_dec_func;
    logic        w_dec_bsel;
    logic [31:0] w_dec_immed;
    logic [4:0]  w_dec_rfa, w_dec_rfb, w_dec_dest;
    logic        w_dec_arith, w_dec_illegal;

    state_t      state_q, state_d;
    logic [3:0]  func_q, func_d;
    logic        bsel_q, bsel_d;
    logic [31:0] immed_q, immed_d;
    logic [4:0]  rfa_q, rfa_d, rfb_q, rfb_d, dest_q, dest_d;
    logic        arith_q, arith_d, illegal_q, illegal_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic        w_in_wb;

`ifdef ALU_ISSUE_BRANCH_EN
    br_kind_t    w_dec_br;
    br_kind_t    br_q, br_d;
    logic        zero_q, zero_d;
    logic [31:0] br_off_q, br_off_d;
`endif

    // Opcode decode; unlisted opcodes become illegal with all ALU controls cleared
    always_comb begin
        w_dec_func    = c_func_add;
        w_dec_bsel    = 1'b0;
        w_dec_immed   = 32'h0;
        w_dec_rfa     = w_rs;
        w_dec_rfb     = w_rt;
        w_dec_dest    = w_rd;
        w_dec_arith   = 1'b1;
        w_dec_illegal = 1'b0;
`ifdef ALU_ISSUE_BRANCH_EN
        w_dec_br      = BR_NONE;
`endif
        case (w_opcode)
            c_op_rtype: w_dec_func = bus.Instr[3:0];
            c_op_addi: begin
                w_dec_bsel  = 1'b1;
                w_dec_immed = {{16{w_imm[15]}}, w_imm};
            end
            c_op_li: begin
                w_dec_rfa   = 5'd0;
                w_dec_bsel  = 1'b1;
                w_dec_immed = {{16{w_imm[15]}}, w_imm};
            end
            c_op_lui: begin
                w_dec_rfa   = 5'd0;
                w_dec_bsel  = 1'b1;
                w_dec_immed = {w_imm, 16'h0};
            end
            c_op_andi: begin
                w_dec_func  = c_func_and;
                w_dec_bsel  = 1'b1;
                w_dec_immed = {16'h0, w_imm};
            end
            c_op_ori: begin
                w_dec_func  = c_func_or;
                w_dec_bsel  = 1'b1;
                w_dec_immed = {16'h0, w_imm};
            end
`ifdef ALU_ISSUE_BRANCH_EN
            c_op_beq, c_op_bne: begin
                w_dec_func  = c_func_sub;
                w_dec_rfb   = w_rd;
                w_dec_arith = 1'b0;
                w_dec_br    = (w_opcode == c_op_beq) ? BR_EQ : BR_NE;
            end
            c_op_b: begin
                w_dec_arith = 1'b0;
                w_dec_br    = BR_ALWAYS;
            end
`endif
            default: begin
                w_dec_rfa     = 5'd0;
                w_dec_rfb     = 5'd0;
                w_dec_dest    = 5'd0;
                w_dec_arith   = 1'b0;
                w_dec_illegal = 1'b1;
            end
        endcase
    end

    // Next-state and held-control logic: latch on accept, capture ALU result
    // leaving EXEC, clear everything when WB completes
    always_comb begin
        state_d   = state_q;
        func_d    = func_q;
        bsel_d    = bsel_q;
        immed_d   = immed_q;
        rfa_d     = rfa_q;
        rfb_d     = rfb_q;
        dest_d    = dest_q;
        arith_d   = arith_q;
        illegal_d = illegal_q;
        alu_out_d = alu_out_q;
`ifdef ALU_ISSUE_BRANCH_EN
        br_d      = br_q;
        zero_d    = zero_q;
        br_off_d  = br_off_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.Instr_valid) begin
                    state_d   = DECODE;
                    func_d    = w_dec_func;
                    bsel_d    = w_dec_bsel;
                    immed_d   = w_dec_immed;
                    rfa_d     = w_dec_rfa;
                    rfb_d     = w_dec_rfb;
                    dest_d    = w_dec_dest;
                    arith_d   = w_dec_arith;
                    illegal_d = w_dec_illegal;
`ifdef ALU_ISSUE_BRANCH_EN
                    br_d      = w_dec_br;
                    br_off_d  = (w_dec_br != BR_NONE) ?
                                {{14{w_imm[15]}}, w_imm, 2'b00} : 32'h0;
`endif
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                state_d   = WB;
                alu_out_d = bus.ALU_out;
`ifdef ALU_ISSUE_BRANCH_EN
                zero_d    = bus.zero;
`endif
            end
            default: begin
                state_d   = IDLE;
                func_d    = 4'h0;
                bsel_d    = 1'b0;
                immed_d   = 32'h0;
                rfa_d     = 5'd0;
                rfb_d     = 5'd0;
                dest_d    = 5'd0;
                arith_d   = 1'b0;
                illegal_d = 1'b0;
                alu_out_d = 32'h0;
`ifdef ALU_ISSUE_BRANCH_EN
                br_d      = BR_NONE;
                zero_d    = 1'b0;
                br_off_d  = 32'h0;
`endif
            end
        endcase
    end

    // State and held-control registers, cleared asynchronously
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            func_q    <= 4'h0;
            bsel_q    <= 1'b0;
            immed_q   <= 32'h0;
            rfa_q     <= 5'd0;
            rfb_q     <= 5'd0;
            dest_q    <= 5'd0;
            arith_q   <= 1'b0;
            illegal_q <= 1'b0;
            alu_out_q <= 32'h0;
`ifdef ALU_ISSUE_BRANCH_EN
            br_q      <= BR_NONE;
            zero_q    <= 1'b0;
            br_off_q  <= 32'h0;
`endif
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            bsel_q    <= bsel_d;
            immed_q   <= immed_d;
            rfa_q     <= rfa_d;
            rfb_q     <= rfb_d;
            dest_q    <= dest_d;
            arith_q   <= arith_d;
            illegal_q <= illegal_d;
            alu_out_q <= alu_out_d;
`ifdef ALU_ISSUE_BRANCH_EN
            br_q      <= br_d;
            zero_q    <= zero_d;
            br_off_q  <= br_off_d;
`endif
        end
    end

    // Ready is masked by reset so it reads 0 while Reset_n is held low
    assign w_in_wb         = (state_q == WB);
    assign bus.Instr_ready = (state_q == IDLE) && Reset_n;
    assign bus.RF_A_addr   = rfa_q;
    assign bus.RF_B_addr   = rfb_q;
    assign bus.ALU_func    = func_q;
    assign bus.ALU_Bin_sel = bsel_q;
    assign bus.Immed       = immed_q;
    assign bus.RF_WrEn     = w_in_wb && arith_q && (dest_q != 5'd0);
    assign bus.RF_Wr_addr  = dest_q;
    assign bus.RF_WrData   = alu_out_q;
    assign bus.Done        = w_in_wb;
    assign bus.Illegal     = w_in_wb && illegal_q;

`ifdef ALU_ISSUE_BRANCH_EN
    assign bus.Branch_taken  = w_in_wb && ((br_q == BR_ALWAYS) ||
                                           ((br_q == BR_EQ) &&  zero_q) ||
                                           ((br_q == BR_NE) && !zero_q));
    assign bus.Branch_offset = br_off_q;
`else
    assign bus.Branch_taken  = 1'b0;
    assign bus.Branch_offset = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Brief    : Self-checking bench for alu_issue_ctrl: table of directed
//            instructions plus reset-abort and back-to-back sequences.
//            Branch expectations follow ALU_ISSUE_BRANCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] alu;
        logic        zero;
        logic        chk_alu;
        logic [3:0]  func;
        logic        bsel;
        logic [31:0] immed;
        logic        chk_rf;
        logic [4:0]  rfa;
        logic [4:0]  rfb;
        logic        wren;
        logic [4:0]  waddr;
        logic        ill;
        logic        is_br;
        logic        taken;
        logic [31:0] off;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [31:0] instr, logic [31:0] alu,
                                logic zero, logic chk_alu, logic [3:0] func,
                                logic bsel, logic [31:0] immed, logic chk_rf,
                                logic [4:0] rfa, logic [4:0] rfb, logic wren,
                                logic [4:0] waddr, logic ill, logic is_br,
                                logic taken, logic [31:0] off);
        vec_t v;
        v.name = name; v.instr = instr; v.alu = alu; v.zero = zero;
        v.chk_alu = chk_alu; v.func = func; v.bsel = bsel; v.immed = immed;
        v.chk_rf = chk_rf; v.rfa = rfa; v.rfb = rfb; v.wren = wren;
        v.waddr = waddr; v.ill = ill; v.is_br = is_br; v.taken = taken;
        v.off = off;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_ctrl(input vec_t v, input string stage);
        if (v.chk_alu) begin
            chk({v.name, " ", stage, " ALU_func"},    32'(bus.ALU_func),    32'(v.func));
            chk({v.name, " ", stage, " ALU_Bin_sel"}, 32'(bus.ALU_Bin_sel), 32'(v.bsel));
            chk({v.name, " ", stage, " Immed"},       bus.Immed,            v.immed);
        end
        if (v.chk_rf) begin
            chk({v.name, " ", stage, " RF_A_addr"}, 32'(bus.RF_A_addr), 32'(v.rfa));
            chk({v.name, " ", stage, " RF_B_addr"}, 32'(bus.RF_B_addr), 32'(v.rfb));
        end
    endtask

    // One instruction from IDLE through WB back to IDLE; starts and ends at a negedge
    task automatic run_vec(input vec_t v);
        chk({v.name, " ready_idle"}, 32'(bus.Instr_ready), 32'd1);
        bus.Instr       = v.instr;
        bus.Instr_valid = 1'b1;
        @(negedge clk);                         // DECODE
        bus.Instr_valid = 1'b0;
        bus.Instr       = 32'h0;
        chk({v.name, " ready_busy"}, 32'(bus.Instr_ready), 32'd0);
        chk_ctrl(v, "decode");
        @(negedge clk);                         // EXEC
        bus.ALU_out = v.alu;
        bus.zero    = v.zero;
        chk({v.name, " done_exec"}, 32'(bus.Done), 32'd0);
        @(negedge clk);                         // WB
        bus.ALU_out = 32'h0;
        bus.zero    = 1'b0;
        chk_ctrl(v, "wb");
        chk({v.name, " Done"},         32'(bus.Done),         32'd1);
        chk({v.name, " RF_WrEn"},      32'(bus.RF_WrEn),      32'(v.wren));
        if (v.wren) begin
            chk({v.name, " RF_Wr_addr"}, 32'(bus.RF_Wr_addr), 32'(v.waddr));
            chk({v.name, " RF_WrData"},  bus.RF_WrData,       v.alu);
        end
        chk({v.name, " Illegal"},      32'(bus.Illegal),      32'(v.ill));
        chk({v.name, " Branch_taken"}, 32'(bus.Branch_taken), 32'(v.taken));
        if (v.is_br)
            chk({v.name, " Branch_offset"}, bus.Branch_offset, v.off);
        @(negedge clk);                         // IDLE
        chk({v.name, " done_after"}, 32'(bus.Done),        32'd0);
        chk({v.name, " wren_after"}, 32'(bus.RF_WrEn),     32'd0);
        chk({v.name, " ready_after"}, 32'(bus.Instr_ready), 32'd1);
    endtask

    // Reset asserted during EXEC of an addi must abandon it silently
    task automatic reset_mid_exec();
        logic saw;
        saw = 1'b0;
        bus.Instr       = 32'hC023FFFF;
        bus.Instr_valid = 1'b1;
        @(negedge clk);                         // DECODE
        bus.Instr_valid = 1'b0;
        @(negedge clk);                         // EXEC
        bus.ALU_out = 32'd9;
        rst_n = 1'b0;
        #1;
        chk("rst_exec ready_low", 32'(bus.Instr_ready), 32'd0);
        chk("rst_exec Immed",     bus.Immed,            32'h0);
        chk("rst_exec Bin_sel",   32'(bus.ALU_Bin_sel), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.Done || bus.RF_WrEn || bus.Branch_taken) saw = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.ALU_out = 32'h0;
        #1;
        chk("rst_exec ready_release", 32'(bus.Instr_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            if (bus.Done || bus.RF_WrEn || bus.Branch_taken) saw = 1'b1;
        end
        chk("rst_exec no_pulse", 32'(saw), 32'd0);
        chk("rst_exec idle",     32'(bus.Instr_ready), 32'd1);
    endtask

    // Valid held high over three instructions; Instr changes while busy
    task automatic back_to_back();
        logic [31:0] prog [3];
        int          acc  [3];
        logic [4:0]  wa[$];
        int          n;
        logic        took;
        prog[0] = 32'hC02A0001;                 // addi rd=10
        prog[1] = 32'hC02B0001;                 // addi rd=11
        prog[2] = 32'hC02C0001;                 // addi rd=12
        acc[0] = -1; acc[1] = -1; acc[2] = -1;
        n = 0;
        bus.Instr       = prog[0];
        bus.Instr_valid = 1'b1;
        bus.ALU_out     = 32'h77;
        for (int c = 0; c < 14; c++) begin
            took = 1'b0;
            if (bus.RF_WrEn) wa.push_back(bus.RF_Wr_addr);
            if (bus.Instr_ready && bus.Instr_valid && n < 3) begin
                acc[n] = c;
                n++;
                took = 1'b1;
            end
            @(negedge clk);
            if (took) begin
                if (n < 3) bus.Instr = prog[n];
                else       bus.Instr_valid = 1'b0;
            end
        end
        bus.ALU_out = 32'h0;
        chk("b2b accept0", 32'(acc[0]), 32'd0);
        chk("b2b accept1", 32'(acc[1]), 32'd4);
        chk("b2b accept2", 32'(acc[2]), 32'd8);
        chk("b2b writes",  32'(wa.size()), 32'd3);
        if (wa.size() == 3) begin
            chk("b2b waddr0", 32'(wa[0]), 32'd10);
            chk("b2b waddr1", 32'(wa[1]), 32'd11);
            chk("b2b waddr2", 32'(wa[2]), 32'd12);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        //          name      instr         alu           z  ca func bs immed         cr rfa rfb we wa  il br tk off
        vecs.push_back(mk("addi",  32'hC023FFFF, 32'd9,        0, 1, 4'h0, 1, 32'hFFFFFFFF, 1, 5'd1, 5'd31, 1, 5'd3, 0, 0, 0, 32'h0));
        vecs.push_back(mk("ori",   32'hCC458001, 32'h12345678, 0, 1, 4'h3, 1, 32'h00008001, 1, 5'd2, 5'd16, 1, 5'd5, 0, 0, 0, 32'h0));
        vecs.push_back(mk("lui",   32'hE4871234, 32'h12340000, 0, 1, 4'h0, 1, 32'h12340000, 1, 5'd0, 5'd2,  1, 5'd7, 0, 0, 0, 32'h0));
        vecs.push_back(mk("r_rd0", 32'h80201001, 32'h55,       0, 1, 4'h1, 0, 32'h0,        1, 5'd1, 5'd2,  0, 5'd0, 0, 0, 0, 32'h0));
        vecs.push_back(mk("r_add", 32'h80692005, 32'hDEADBEEF, 0, 1, 4'h5, 0, 32'h0,        1, 5'd3, 5'd4,  1, 5'd9, 0, 0, 0, 32'h0));
        vecs.push_back(mk("andi",  32'hC8C2F0F0, 32'h50,       0, 1, 4'h2, 1, 32'h0000F0F0, 1, 5'd6, 5'd30, 1, 5'd2, 0, 0, 0, 32'h0));
        vecs.push_back(mk("li",    32'hE1048000, 32'h3,        0, 1, 4'h0, 1, 32'hFFFF8000, 1, 5'd0, 5'd16, 1, 5'd4, 0, 0, 0, 32'h0));
        vecs.push_back(mk("ill",   32'h54230042, 32'h99,       0, 1, 4'h0, 0, 32'h0,        0, 5'd0, 5'd0,  0, 5'd0, 1, 0, 0, 32'h0));
`ifdef ALU_ISSUE_BRANCH_EN
        vecs.push_back(mk("beq_z1", 32'h0041FFFE, 32'h0, 1, 1, 4'h1, 0, 32'h0, 1, 5'd2, 5'd1, 0, 5'd0, 0, 1, 1, 32'hFFFFFFF8));
        vecs.push_back(mk("beq_z0", 32'h0041FFFE, 32'h0, 0, 1, 4'h1, 0, 32'h0, 1, 5'd2, 5'd1, 0, 5'd0, 0, 1, 0, 32'hFFFFFFF8));
        vecs.push_back(mk("bne_z1", 32'h0441FFFE, 32'h0, 1, 1, 4'h1, 0, 32'h0, 1, 5'd2, 5'd1, 0, 5'd0, 0, 1, 0, 32'hFFFFFFF8));
        vecs.push_back(mk("bne_z0", 32'h0441FFFE, 32'h0, 0, 1, 4'h1, 0, 32'h0, 1, 5'd2, 5'd1, 0, 5'd0, 0, 1, 1, 32'hFFFFFFF8));
        vecs.push_back(mk("b",      32'hFC000010, 32'h0, 1, 0, 4'h0, 0, 32'h0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 32'h00000040));
`else
        vecs.push_back(mk("beq_off", 32'h0041FFFE, 32'h0, 1, 1, 4'h0, 0, 32'h0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0, 32'h0));
        vecs.push_back(mk("bne_off", 32'h0441FFFE, 32'h0, 0, 1, 4'h0, 0, 32'h0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0, 32'h0));
        vecs.push_back(mk("b_off",   32'hFC000010, 32'h0, 1, 1, 4'h0, 0, 32'h0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0, 32'h0));
`endif

        rst_n           = 1'b0;
        bus.Instr       = 32'h0;
        bus.Instr_valid = 1'b0;
        bus.ALU_out     = 32'h0;
        bus.zero        = 1'b0;
        #1;
        chk("reset ready_low", 32'(bus.Instr_ready), 32'd0);
        chk("reset Done",      32'(bus.Done),        32'd0);
        chk("reset RF_WrEn",   32'(bus.RF_WrEn),     32'd0);
        chk("reset Immed",     bus.Immed,            32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset ready_release", 32'(bus.Instr_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i]);

        reset_mid_exec();
        run_vec(vecs[0]);
        back_to_back();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Clk  in  1  rising-edge system clock.
REQ-002 Reset_n  in  1  asynchronous, active-low reset.
REQ-003 Instr  in  32  instruction word: opcode[31:26], rs[25:21], rd[20:16], rt[15:11], func[3:0], imm[15:0].
REQ-004 Instr_valid  in  1  Instr is offered this cycle.
REQ-005 Instr_ready  out  1  block accepts Instr this cycle.
REQ-006 RF_A_addr / RF_B_addr  out  5 each  register-file read addresses feeding the ALU stage RF_A/RF_B.
REQ-007 ALU_func  out  4 ; ALU_Bin_sel  out  1 ; Immed  out  32  ALU stage controls and extended immediate.
REQ-008 ALU_out  in  32 ; zero  in  1  ALU stage results.
REQ-009 RF_WrEn  out  1 ; RF_Wr_addr  out  5 ; RF_WrData  out  32  write-back port.
REQ-010 Branch_taken  out  1 ; Branch_offset  out  32  branch request to fetch.
REQ-011 Done  out  1 ; Illegal  out  1  one-cycle completion and bad-opcode pulses.

Function
REQ-012 FSM states SHALL be IDLE, DECODE, EXEC, WB; Instr_ready SHALL be 1 only in IDLE.
REQ-013 Instr_valid&Instr_ready at edge E0 SHALL latch Instr and enter DECODE; E0+1 -> EXEC; E0+2 -> WB; E0+3 -> IDLE.
REQ-014 Instr_valid while not ready SHALL be ignored (no latch, no state change).
REQ-015 RF_A_addr=rs; RF_B_addr=rt for R-type, rd for beq/bne; held from DECODE through WB.
REQ-016 Opcode 100000 (R-type): ALU_func=func, ALU_Bin_sel=0, dest=rd.
REQ-017 addi 110000: func 0000, Bin_sel 1, Immed=sign-extend(imm); li 111000: RF_A_addr forced 0, func 0000, sign-extend; lui 111001: RF_A_addr 0, func 0000, Immed=imm<<16.
REQ-018 andi 110010 / ori 110011: func 0010 / 0011, Bin_sel 1, Immed=zero-extend(imm).
REQ-019 ALU_func, ALU_Bin_sel, Immed SHALL be stable from DECODE through WB; ALU_out and zero SHALL be registered on the EXEC->WB edge.
REQ-020 In WB, arithmetic ops SHALL pulse RF_WrEn for one cycle with RF_WrData=registered ALU_out, RF_Wr_addr=rd; rd==0 SHALL suppress RF_WrEn.
REQ-021 Done SHALL pulse exactly in WB for every accepted instruction, including illegal ones.
REQ-022 Unlisted opcode SHALL pulse Illegal in WB with no RF_WrEn and no Branch_taken; ALU controls 0.
REQ-023 Back-to-back: Instr held valid SHALL be accepted every 4 cycles (throughput 1/4).

Reset
REQ-024 Reset_n low SHALL immediately force IDLE and all outputs to 0 except Instr_ready (1 after release in IDLE; 0 while Reset_n low).
REQ-025 Reset mid-operation SHALL abandon the instruction with no RF_WrEn, Done or Branch_taken pulse.

Configuration
REQ-026 Macro ALU_ISSUE_BRANCH_EN defined: beq 000000 and bne 000001 SHALL use func 0001, Bin_sel 0, Branch_offset=sign-extend(imm)<<2, Branch_taken pulsed in WB when zero==1 (beq) / zero==0 (bne); b 111111 SHALL pulse Branch_taken unconditionally; no RF_WrEn for branches.
REQ-027 Macro undefined: opcodes 000000, 000001, 111111 SHALL be illegal per REQ-022; Branch_taken and Branch_offset tied to 0.

Verification
REQ-028 Reset_n low mid-EXEC of addi -> no RF_WrEn/Done; after release Instr_ready=1, state IDLE.
REQ-029 addi rd=3, rs=1, imm=0xFFFF, ALU_out returns 9 -> Immed=0xFFFFFFFF, Bin_sel=1, func 0000, RF_WrEn at E0+2 cycle, addr 3, data 9, Done same cycle.
REQ-030 ori imm=0x8001 -> Immed=0x00008001, func 0011; lui imm=0x1234 -> Immed=0x12340000, RF_A_addr=0.
REQ-031 R-type rd=0, func 0001 -> Done pulse, RF_WrEn stays 0.
REQ-032 ALU_ISSUE_BRANCH_EN: beq imm=0xFFFE, zero=1 -> Branch_taken=1, Branch_offset=0xFFFFFFF8; bne same with zero=1 -> Branch_taken=0; without macro beq -> Illegal=1.
REQ-033 Instr_valid held high with 3 instructions -> accepts at cycles 0, 4, 8; Instr changes during DECODE/EXEC ignored.
